pipe_ctrl: RTL
==============

# pipe_ctrl

Central stall/flush sequencer for the 16-bit five-stage pipeline. It produces the load-enable and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register banks, and detects load-use hazards. It runs the request/done handshake with multi-cycle data memory and drains the pipeline on HALT. It sits beside the datapath and consumes only stage-register control fields.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- id_rs, id_rt  in  3  source register fields of the instruction in ID
- id_rs_used, id_rt_used  in  1  the instruction in ID reads rs / rt
- halt_id  in  1  the instruction in ID is HALT
- idex_write_r  in  3  destination register of the instruction in EX
- idex_MEM_READ, idex_REG_WRITE  in  1  control bits of the instruction in EX
- exmem_mem_req  in  1  the instruction in MEM performs a load or store
- exmem_branch_taken  in  1  the instruction in MEM redirects the PC
- mem_done  in  1  data memory completes the current request; may rise in the same cycle as mem_go
- mem_go  out  1  one-cycle request strobe to data memory
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  stage register load enables
- ifid_flush, idex_flush, memwb_bubble  out  1  load a NOP / zero-control into that register
- halted  out  1  HALT has retired; held until rst
- stall_cycles  out  16  saturating count of cycles spent in MEM_WAIT

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALTED. A 1-bit ret register holds the state to resume (RUN or DRAIN). A 2-bit drain counter, cnt, tracks HALT's progress.
- Definitions:
  - load_use = idex_MEM_READ & idex_REG_WRITE & ((id_rs_used & id_rs==idex_write_r) | (id_rt_used & id_rt==idex_write_r)).
  - adv = 1 when the pipeline advances this cycle.
- Memory request, in RUN or DRAIN with exmem_mem_req=1:
  - mem_go=1.
  - If mem_done=1 in the same cycle: no stall, normal advance.
  - Otherwise: next state MEM_WAIT, ret := current state.
- MEM_WAIT:
  - All enables 0 except memwb_en=1 with memwb_bubble=1, so no double writeback. mem_go=0.
  - On mem_done=1: enables as in the ret state; next state = ret.
- Priority within RUN/DRAIN: mem stall > branch flush > load-use > normal.
- Branch flush (exmem_branch_taken, no mem stall): all enables 1, ifid_flush=1, idex_flush=1. A branch load-use condition is ignored.
- Load-use (no stall, no branch): pc_en=0, ifid_en=0, idex_flush=1, others enabled.
- RUN with halt_id=1 and adv, no branch, no load-use: next state DRAIN, cnt=0.
- DRAIN:
  - pc_en=0, ifid_flush=1, idex_flush=1; the other enables are 1.
  - cnt increments on each adv cycle.
  - cnt==2 with adv: next state HALTED.
  - exmem_branch_taken with cnt==0 (an older branch in MEM) cancels the drain: flush as above, next state RUN. exmem_branch_taken is ignored for cnt≥1.
- HALTED: all enables 0, flushes 0, mem_go=0, halted=1. Leaves only on rst.
- stall_cycles increments each MEM_WAIT cycle and saturates at 0xFFFF.

## Timing
- rst=1 (any state, including mid-MEM_WAIT):
  - Next state RUN, cnt=0, ret=RUN, stall_cycles=0.
  - During the rst cycle all outputs are 0 and halted=0.
  - An outstanding memory request is abandoned; a late mem_done is ignored unless in MEM_WAIT.
- All outputs are combinational from state plus the current inputs; there is no registered-output latency.
- Load-use costs exactly 1 bubble. Branch costs 2 flushed slots. A memory miss costs N stall cycles, where mem_done arrives N cycles after mem_go.
- HALT decoded in ID in cycle T with no stalls: DRAIN in T+1..T+3, halted=1 from T+4.
- mem_done while not in MEM_WAIT and mem_go=0: ignored.

## Test plan
- Load-use: LD r3 in EX, ID reads r3 via rs → pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle; the next cycle is all-enable.
- Memory miss: exmem_mem_req=1, mem_done 3 cycles after mem_go → mem_go for 1 cycle, 3 MEM_WAIT cycles with memwb_bubble=1, resume; stall_cycles=3.
- Same-cycle done: exmem_mem_req=1 and mem_done=1 together → no MEM_WAIT, stall_cycles unchanged.
- Simultaneous events: exmem_branch_taken=1 together with load_use=1 → flush both IF/ID and ID/EX, pc_en=1, no load-use bubble.
- HALT drain:
  - halt_id at cycle 10, 2-cycle miss at cycle 12 → halted=1 at cycle 16.
  - Repeat with a branch at cycle 11 → returns to RUN, halted stays 0.
- Reset during MEM_WAIT → next cycle RUN, all enables 1, stall_cycles=0; a stray mem_done produces no effect.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: stage enables, bubbles,
// load-use detection, data-memory handshake and HALT drain.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic        halt_id,
  input  logic [2:0]  idex_write_r,
  input  logic        idex_MEM_READ,
  input  logic        idex_REG_WRITE,
  input  logic        exmem_mem_req,
  input  logic        exmem_branch_taken,
  input  logic        mem_done,
  output logic        mem_go,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_bubble,
  output logic        halted,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  state_t     state, state_next;
  logic       ret, ret_next;
  logic [1:0] cnt, cnt_next;
  logic       load_use;
  logic       eval;
  logic       drain_mode;
  logic       mem_ready;

  assign load_use = idex_MEM_READ & idex_REG_WRITE &
                    ((id_rs_used & (id_rs == idex_write_r)) |
                     (id_rt_used & (id_rt == idex_write_r)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      ret          <= 1'b0;
      cnt          <= 2'd0;
      stall_cycles <= 16'd0;
    end else begin
      state <= state_next;
      ret   <= ret_next;
      cnt   <= cnt_next;
      if (state == MEM_WAIT && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

  // eval/drain_mode select the RUN or DRAIN behaviour; MEM_WAIT reuses it
  // on the completion cycle with the saved ret state.
  always_comb begin
    mem_go       = 1'b0;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    halted       = 1'b0;
    state_next   = state;
    ret_next     = ret;
    cnt_next     = cnt;
    eval         = 1'b0;
    drain_mode   = 1'b0;
    mem_ready    = 1'b1;

    case (state)
      RUN: begin
        eval      = 1'b1;
        mem_go    = exmem_mem_req;
        mem_ready = !exmem_mem_req || mem_done;
      end
      DRAIN: begin
        eval       = 1'b1;
        drain_mode = 1'b1;
        mem_go     = exmem_mem_req;
        mem_ready  = !exmem_mem_req || mem_done;
      end
      MEM_WAIT: begin
        if (mem_done) begin
          eval       = 1'b1;
          drain_mode = ret;
        end else begin
          memwb_en     = 1'b1;
          memwb_bubble = 1'b1;
        end
      end
      HALTED: halted = 1'b1;
      default: state_next = RUN;
    endcase

    if (eval) begin
      if (!mem_ready) begin
        memwb_en     = 1'b1;
        memwb_bubble = 1'b1;
        state_next   = MEM_WAIT;
        ret_next     = drain_mode;
      end else if (drain_mode && !(exmem_branch_taken && cnt == 2'd0)) begin
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        cnt_next   = cnt + 2'd1;
        state_next = (cnt == 2'd2) ? HALTED : DRAIN;
      end else begin
        // Normal advance; an older branch in MEM also cancels a fresh drain.
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        state_next = RUN;
        if (exmem_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          cnt_next   = 2'd0;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (halt_id) begin
          state_next = DRAIN;
          cnt_next   = 2'd0;
        end
      end
    end

    if (rst) begin
      mem_go       = 1'b0;
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_bubble = 1'b0;
      halted       = 1'b0;
    end
  end

endmodule
